// File: rtl/soc_uart_pkg.sv
// Shared definitions for the soc_uart buffering stage.
//   UART_DATA_W      : width of one UART byte.
//   tx_drain_state_t : states of the TX drain handshake towards soc_uart.
//   rx_cap_state_t   : states of the RX capture/acknowledge handshake.
package soc_uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        T_IDLE,
        T_HOLD
    } tx_drain_state_t;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rx_cap_state_t;

endpackage

// File: rtl/soc_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head read.
//   clk, rst_n : clock and asynchronous active-low reset
//   push/wdata : write request and data; ignored while full
//   pop        : consume head entry; ignored while empty
//   rdata      : head entry (valid while !empty)
//   count      : occupancy, 0 .. 2**DEPTH_LOG2
//   full/empty : occupancy flags
module soc_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Guarding each side with its own flag gives the required corner cases:
    // at empty only the push lands, at full only the pop lands.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/soc_uart_fifo.sv
// Buffering/handshake stage between bus-side register logic and soc_uart.
//   uclk, res_n         : UART clock (16x baud) and async active-low reset
//   tx_push/tx_wdata    : producer byte into the TX FIFO (accepted while tx_ready)
//   rx_valid/rx_rdata   : RX FIFO head; rx_pop consumes it
//   tx_count/rx_count   : FIFO occupancies
//   tx_idle             : nothing queued, nothing being launched, soc_uart empty
//   st_rx_*             : sticky RX status, cleared by clr_status (set wins)
//   u_*                 : handshake with soc_uart (tx_data/start_tx/tx_empty,
//                         rx_full/rx_data/rx_overrun/rx_break/ack)
module soc_uart_fifo
    import soc_uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                   uclk,
    input  logic                   res_n,
    input  logic                   tx_push,
    input  logic [UART_DATA_W-1:0] tx_wdata,
    output logic                   tx_ready,
    output logic                   rx_valid,
    output logic [UART_DATA_W-1:0] rx_rdata,
    input  logic                   rx_pop,
    output logic [DEPTH_LOG2:0]    tx_count,
    output logic [DEPTH_LOG2:0]    rx_count,
    output logic                   tx_idle,
    output logic                   st_rx_overflow,
    output logic                   st_rx_overrun,
    output logic                   st_rx_break,
    input  logic                   clr_status,
    output logic [UART_DATA_W-1:0] u_tx_data,
    output logic                   u_start_tx,
    input  logic                   u_tx_empty,
    input  logic                   u_rx_full,
    input  logic [UART_DATA_W-1:0] u_rx_data,
    input  logic                   u_rx_overrun,
    input  logic                   u_rx_break,
    output logic                   u_ack
);

    tx_drain_state_t tx_state, tx_state_nxt;
    rx_cap_state_t   rx_state, rx_state_nxt;

    logic tx_fifo_full, tx_fifo_empty, tx_pop;
    logic rx_fifo_full, rx_fifo_empty, rx_push;
    logic overflow_set;

    soc_sync_fifo #(
        .WIDTH      (UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (uclk),
        .rst_n (res_n),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (u_tx_data),
        .count (tx_count),
        .full  (tx_fifo_full),
        .empty (tx_fifo_empty)
    );

    soc_sync_fifo #(
        .WIDTH      (UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (uclk),
        .rst_n (res_n),
        .push  (rx_push),
        .wdata (u_rx_data),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .count (rx_count),
        .full  (rx_fifo_full),
        .empty (rx_fifo_empty)
    );

    // The FIFO itself reports not-full during reset; gating with res_n keeps
    // every output low while reset is held.
    assign tx_ready = res_n & ~tx_fifo_full;
    assign rx_valid = ~rx_fifo_empty;

    // ---------------- TX drain FSM ----------------
    always_ff @(posedge uclk or negedge res_n) begin
        if (!res_n) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            T_IDLE:  if (!tx_fifo_empty && u_tx_empty) tx_state_nxt = T_HOLD;
            // soc_uart leaving IDLE (tx_empty falls) is the only proof it took
            // the byte; tx_empty is also high in its STOP state, where
            // start_tx is ignored, so hold until the fall.
            T_HOLD:  if (!u_tx_empty) tx_state_nxt = T_IDLE;
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    // start_tx is a pure decode of the state register, so it is glitch-free.
    always_comb begin
        u_start_tx = (tx_state == T_HOLD);
        tx_pop     = (tx_state == T_HOLD) && !u_tx_empty;
        tx_idle    = res_n && tx_fifo_empty && (tx_state == T_IDLE) && u_tx_empty;
    end

    // ---------------- RX capture FSM ----------------
    always_ff @(posedge uclk or negedge res_n) begin
        if (!res_n) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            R_IDLE:  if (u_rx_full || u_rx_break || u_rx_overrun) rx_state_nxt = R_ACK;
            // One cycle in R_ACK lets soc_uart drop rx_full before we look again.
            R_ACK:   rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        u_ack        = (rx_state == R_ACK);
        rx_push      = (rx_state == R_IDLE) && u_rx_full;
        overflow_set = rx_push && rx_fifo_full;
    end

    // ---------------- Sticky status ----------------
    always_ff @(posedge uclk or negedge res_n) begin
        if (!res_n) begin
            st_rx_overflow <= 1'b0;
            st_rx_overrun  <= 1'b0;
            st_rx_break    <= 1'b0;
        end else begin
            if (overflow_set)    st_rx_overflow <= 1'b1;
            else if (clr_status) st_rx_overflow <= 1'b0;

            if (u_rx_overrun)    st_rx_overrun <= 1'b1;
            else if (clr_status) st_rx_overrun <= 1'b0;

            if (u_rx_break)      st_rx_break <= 1'b1;
            else if (clr_status) st_rx_break <= 1'b0;
        end
    end

endmodule

// File: tb/tb_soc_uart_fifo.sv
// Self-checking bench for soc_uart_fifo with a behavioural soc_uart stand-in.
module tb_soc_uart_fifo;

    localparam int DL2   = 3;
    localparam int DEPTH = 8;

    logic           uclk = 1'b0;
    logic           res_n = 1'b1;
    logic           tx_push = 1'b0;
    logic [7:0]     tx_wdata = '0;
    logic           tx_ready;
    logic           rx_valid;
    logic [7:0]     rx_rdata;
    logic           rx_pop = 1'b0;
    logic [DL2:0]   tx_count;
    logic [DL2:0]   rx_count;
    logic           tx_idle;
    logic           st_rx_overflow, st_rx_overrun, st_rx_break;
    logic           clr_status = 1'b0;
    logic [7:0]     u_tx_data;
    logic           u_start_tx;
    logic           u_tx_empty = 1'b1;
    logic           u_rx_full = 1'b0;
    logic [7:0]     u_rx_data = '0;
    logic           u_rx_overrun = 1'b0;
    logic           u_rx_break = 1'b0;
    logic           u_ack;

    always #5 uclk = ~uclk;

    soc_uart_fifo #(.DEPTH_LOG2(DL2)) dut (
        .uclk(uclk), .res_n(res_n), .tx_push(tx_push), .tx_wdata(tx_wdata),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_rdata(rx_rdata), .rx_pop(rx_pop),
        .tx_count(tx_count), .rx_count(rx_count), .tx_idle(tx_idle),
        .st_rx_overflow(st_rx_overflow), .st_rx_overrun(st_rx_overrun), .st_rx_break(st_rx_break),
        .clr_status(clr_status), .u_tx_data(u_tx_data), .u_start_tx(u_start_tx),
        .u_tx_empty(u_tx_empty), .u_rx_full(u_rx_full), .u_rx_data(u_rx_data),
        .u_rx_overrun(u_rx_overrun), .u_rx_break(u_rx_break), .u_ack(u_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- soc_uart stand-in ----------------
    // 0 = IDLE (tx_empty=1, samples start_tx), 1 = sending (tx_empty=0),
    // 2 = STOP (tx_empty=1, start_tx ignored).
    int         ust = 0;
    int         ucnt = 0;
    logic [7:0] cur = '0;
    logic       stall = 1'b0;
    logic       loopback = 1'b0;
    logic [7:0] sent_q[$];
    logic [7:0] rxin_q[$];
    int         bursts = 0;
    int         acks = 0;
    logic       prev_start = 1'b0;
    logic       prev_ack = 1'b0;

    initial begin
        forever begin
            @(posedge uclk); #1;
            if (!res_n) begin
                ust = 0; ucnt = 0; u_tx_empty = 1'b1; u_rx_full = 1'b0;
                rxin_q.delete(); prev_start = 1'b0; prev_ack = 1'b0;
                continue;
            end
            if (u_start_tx && !prev_start) bursts++;
            if (u_ack && !prev_ack) acks++;
            prev_start = u_start_tx;
            prev_ack   = u_ack;
            case (ust)
                0: if (u_start_tx && !stall) begin
                       cur = u_tx_data; u_tx_empty = 1'b0; ust = 1; ucnt = 12;
                   end
                1: begin
                       ucnt = ucnt - 1;
                       if (ucnt == 0) begin
                           u_tx_empty = 1'b1; ust = 2; ucnt = 4;
                           sent_q.push_back(cur);
                           if (loopback) rxin_q.push_back(cur);
                       end
                   end
                default: begin
                       ucnt = ucnt - 1;
                       if (ucnt == 0) ust = 0;
                   end
            endcase
            if (u_rx_full && u_ack) begin
                u_rx_full = 1'b0;
            end else if (!u_rx_full && !u_ack && rxin_q.size() > 0) begin
                u_rx_data = rxin_q.pop_front();
                u_rx_full = 1'b1;
            end
        end
    end

    // ---------------- reference model, checked every negedge ----------------
    logic [7:0] mtx[$];
    logic [7:0] mrx[$];
    logic e_ovf = 1'b0, e_ovr = 1'b0, e_brk = 1'b0;

    always @(negedge uclk) begin
        if (!res_n) begin
            mtx.delete(); mrx.delete();
            e_ovf = 1'b0; e_ovr = 1'b0; e_brk = 1'b0;
            chk("rst_tx_ready", 32'(tx_ready), 0);
            chk("rst_tx_count", 32'(tx_count), 0);
            chk("rst_rx_count", 32'(rx_count), 0);
            chk("rst_start", 32'(u_start_tx), 0);
            chk("rst_ack", 32'(u_ack), 0);
            chk("rst_tx_idle", 32'(tx_idle), 0);
            chk("rst_flags", {29'd0, st_rx_overflow, st_rx_overrun, st_rx_break}, 0);
        end else begin
            logic tpop, tpush, cap, rpop, rfull;
            chk("tx_count", 32'(tx_count), 32'(mtx.size()));
            chk("tx_ready", 32'(tx_ready), 32'(mtx.size() < DEPTH));
            chk("rx_count", 32'(rx_count), 32'(mrx.size()));
            chk("rx_valid", 32'(rx_valid), 32'(mrx.size() > 0));
            if (mrx.size() > 0) chk("rx_rdata", 32'(rx_rdata), 32'(mrx[0]));
            if (u_start_tx) begin
                chk("start_has_data", 32'(mtx.size() > 0), 1);
                if (mtx.size() > 0) chk("u_tx_data", 32'(u_tx_data), 32'(mtx[0]));
            end
            chk("tx_idle", 32'(tx_idle), 32'(mtx.size() == 0 && !u_start_tx && u_tx_empty));
            chk("st_overflow", 32'(st_rx_overflow), 32'(e_ovf));
            chk("st_overrun", 32'(st_rx_overrun), 32'(e_ovr));
            chk("st_break", 32'(st_rx_break), 32'(e_brk));
            // Events at the coming edge, judged on pre-edge occupancy.
            tpop  = u_start_tx && !u_tx_empty && mtx.size() > 0;
            tpush = tx_push && mtx.size() < DEPTH;
            cap   = u_rx_full && !u_ack;
            rpop  = rx_pop && mrx.size() > 0;
            rfull = (mrx.size() == DEPTH);
            if (tpop)  void'(mtx.pop_front());
            if (tpush) mtx.push_back(tx_wdata);
            if (rpop)  void'(mrx.pop_front());
            if (cap && !rfull) mrx.push_back(u_rx_data);
            if (cap && rfull)      e_ovf = 1'b1;
            else if (clr_status)   e_ovf = 1'b0;
            if (u_rx_overrun)      e_ovr = 1'b1;
            else if (clr_status)   e_ovr = 1'b0;
            if (u_rx_break)        e_brk = 1'b1;
            else if (clr_status)   e_brk = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge uclk); #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 1000 && !tx_ready; i++) tick();
        chk("push_wait", 32'(tx_ready), 1);
        tx_push = 1'b1; tx_wdata = b;
        tick();
        tx_push = 1'b0;
    endtask

    task automatic pop_byte(input logic [7:0] b);
        for (int i = 0; i < 2000 && !rx_valid; i++) tick();
        chk("pop_wait", 32'(rx_valid), 1);
        chk("pop_data", 32'(rx_rdata), 32'(b));
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
    endtask

    typedef struct packed {
        logic ovr; logic brk; logic clr; logic e_ovr; logic e_brk;
    } flag_vec_t;

    flag_vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, a0, s0, i;
        logic [7:0] v3 [3];

        // field order: ovr brk clr _ e_ovr e_brk
        tbl[0] = 5'b001_00;
        tbl[1] = 5'b010_01;
        tbl[2] = 5'b000_01;
        tbl[3] = 5'b001_00;
        tbl[4] = 5'b011_01;
        tbl[5] = 5'b101_10;
        tbl[6] = 5'b000_10;
        tbl[7] = 5'b111_11;
        tbl[8] = 5'b001_00;
        v3[0] = 8'h55; v3[1] = 8'hA3; v3[2] = 8'h0F;

        // ---- reset ----
        #2 res_n = 1'b0;
        repeat (3) tick();
        chk("reset_ready", 32'(tx_ready), 0);
        chk("reset_counts", {24'd0, tx_count, rx_count}, 0);
        res_n = 1'b1;
        tick();
        chk("post_reset_ready", 32'(tx_ready), 1);
        chk("post_reset_idle", 32'(tx_idle), 1);

        // ---- three bytes in loopback ----
        loopback = 1'b1;
        b0 = bursts;
        push_byte(v3[0]);
        chk("latency_early", 32'(u_start_tx), 0);
        push_byte(v3[1]);
        chk("latency_1cyc", 32'(u_start_tx), 1);
        push_byte(v3[2]);
        for (i = 0; i < 200 && ust != 2; i++) @(negedge uclk);
        @(negedge uclk);
        chk("stop_start_held", 32'(u_start_tx), 1);
        chk("stop_tx_empty", 32'(u_tx_empty), 1);
        chk("stop_count", 32'(tx_count), 2);
        for (int k = 0; k < 3; k++) pop_byte(v3[k]);
        for (i = 0; i < 500 && !(ust == 0 && sent_q.size() == 3); i++) @(negedge uclk);
        @(negedge uclk);
        chk("loop_sent", 32'(sent_q.size()), 3);
        chk("loop_tx_idle", 32'(tx_idle), 1);
        chk("loop_bursts", 32'(bursts - b0), 3);

        // ---- nine bytes against a depth-8 FIFO ----
        loopback = 1'b0;
        stall = 1'b1;
        sent_q.delete();
        b0 = bursts;
        for (int k = 0; k < 8; k++) push_byte(8'hA0 + 8'(k));
        chk("full_ready", 32'(tx_ready), 0);
        chk("full_count", 32'(tx_count), 8);
        stall = 1'b0;
        push_byte(8'hA8);
        for (i = 0; i < 1500 && sent_q.size() < 9; i++) tick();
        chk("nine_sent", 32'(sent_q.size()), 9);
        for (int k = 0; k < 9 && k < sent_q.size(); k++)
            chk($sformatf("nine_byte%0d", k), 32'(sent_q[k]), 32'(8'hA0 + 8'(k)));
        chk("nine_bursts", 32'(bursts - b0), 9);

        // ---- RX overflow ----
        a0 = acks;
        for (int k = 0; k < 10; k++) rxin_q.push_back(8'h10 + 8'(k));
        for (i = 0; i < 500 && !(rxin_q.size() == 0 && !u_rx_full && acks - a0 == 10); i++) tick();
        tick();
        chk("ovf_count", 32'(rx_count), 8);
        chk("ovf_flag", 32'(st_rx_overflow), 1);
        chk("ovf_acks", 32'(acks - a0), 10);
        for (int k = 0; k < 8; k++) pop_byte(8'h10 + 8'(k));
        chk("ovf_drained", 32'(rx_valid), 0);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("ovf_clear", 32'(st_rx_overflow), 0);

        // ---- break held for 20 cycles ----
        a0 = acks;
        u_rx_break = 1'b1;
        repeat (20) tick();
        u_rx_break = 1'b0;
        repeat (3) tick();
        chk("brk_flag", 32'(st_rx_break), 1);
        chk("brk_no_push", 32'(rx_count), 0);
        chk("brk_acks", 32'(acks - a0), 10);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("brk_clear", 32'(st_rx_break), 0);
        clr_status = 1'b1; u_rx_break = 1'b1; tick();
        clr_status = 1'b0; u_rx_break = 1'b0;
        chk("brk_set_wins", 32'(st_rx_break), 1);
        tick();

        // ---- sticky flag table ----
        for (int k = 0; k < 9; k++) begin
            u_rx_overrun = tbl[k].ovr;
            u_rx_break   = tbl[k].brk;
            clr_status   = tbl[k].clr;
            tick();
            chk($sformatf("tbl%0d_ovr", k), 32'(st_rx_overrun), 32'(tbl[k].e_ovr));
            chk($sformatf("tbl%0d_brk", k), 32'(st_rx_break), 32'(tbl[k].e_brk));
        end
        u_rx_overrun = 1'b0; u_rx_break = 1'b0; clr_status = 1'b0;
        repeat (2) tick();

        // ---- randomized traffic in loopback ----
        loopback = 1'b1;
        b0 = bursts;
        s0 = sent_q.size();
        for (int c = 0; c < 3000; c++) begin
            tx_push      = 1'($urandom_range(0, 1));
            tx_wdata     = 8'($urandom);
            rx_pop       = (c < 1500) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
            u_rx_overrun = ($urandom_range(0, 63) == 0);
            u_rx_break   = ($urandom_range(0, 63) == 0);
            clr_status   = ($urandom_range(0, 31) == 0);
            tick();
        end
        tx_push = 1'b0; rx_pop = 1'b0; u_rx_overrun = 1'b0; u_rx_break = 1'b0; clr_status = 1'b0;
        for (i = 0; i < 5000 && !(tx_count == 0 && ust == 0 && rxin_q.size() == 0 && !u_rx_full); i++) tick();
        repeat (3) tick();
        chk("rand_drained", 32'(tx_count), 0);
        for (i = 0; i < 20 && rx_valid; i++) begin
            rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        end
        chk("rand_rx_empty", 32'(rx_count), 0);
        chk("rand_bursts", 32'(bursts - b0), 32'(sent_q.size() - s0));

        // ---- reset mid-frame ----
        loopback = 1'b0;
        push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
        for (i = 0; i < 200 && ust != 1; i++) @(negedge uclk);
        @(posedge uclk); #3;
        res_n = 1'b0;
        #1;
        chk("mid_rst_tx_count", 32'(tx_count), 0);
        chk("mid_rst_rx_count", 32'(rx_count), 0);
        chk("mid_rst_start", 32'(u_start_tx), 0);
        chk("mid_rst_ack", 32'(u_ack), 0);
        repeat (2) tick();
        res_n = 1'b1;
        tick();
        sent_q.delete();
        chk("resume_ready", 32'(tx_ready), 1);
        push_byte(8'h3C);
        for (i = 0; i < 500 && sent_q.size() < 1; i++) tick();
        chk("resume_sent", 32'(sent_q.size()), 1);
        if (sent_q.size() > 0) chk("resume_byte", 32'(sent_q[0]), 32'h3C);
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
